// File: rtl/aes_pkg.sv
// Shared AES definitions for the decrypt datapath.
//   - block/byte geometry constants
//   - GF(2^8) reduction polynomial and inverse-affine constant
//   - FSM state type for the iterative byte-substitution stages
//   - gf_mul: GF(2^8) multiply modulo AES_POLY
package aes_pkg;

  localparam int unsigned AES_BLOCK_BITS = 128;
  localparam int unsigned AES_BYTE_BITS  = 8;
  localparam int unsigned AES_NUM_BYTES  = 16;

  localparam logic [8:0] AES_POLY         = 9'h11B;
  localparam logic [7:0] AES_INV_AFFINE_C = 8'h05;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } inv_state_e;

  // Shift-and-add multiply; x is doubled (xtime) each step and reduced by
  // the low 8 bits of the polynomial when bit 7 falls off.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? AES_POLY[7:0] : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box, purely combinational (no table).
//   in_byte  : byte to substitute
//   out_byte : InvSbox(in_byte)
// Inverse affine transform first, then multiplicative inverse in GF(2^8)
// computed as a^254 (0 maps naturally to 0).
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  logic [7:0] aff;
  logic [7:0] sq;
  logic [7:0] acc;

  always_comb begin
    aff = {in_byte[6:0], in_byte[7]}
        ^ {in_byte[4:0], in_byte[7:5]}
        ^ {in_byte[1:0], in_byte[7:2]}
        ^ AES_INV_AFFINE_C;
    // acc accumulates a^2 * a^4 * ... * a^128 = a^254
    sq  = gf_mul(aff, aff);
    acc = sq;
    for (int unsigned i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    out_byte = acc;
  end

endmodule

// File: rtl/inv_sub_byte.sv
// Iterative InvSubBytes stage.
//   clk, rst        : clock (rising edge), asynchronous active-low reset
//   inv_valid_in    : upstream state valid
//   inv_ready_out   : stage idle, can accept a state
//   inv_data_in     : 128-bit state to inverse-substitute
//   inv_data_out    : substituted state, 0 unless inv_valid_out
//   inv_valid_out   : result valid (held until inv_ready_in)
//   inv_ready_in    : downstream accepts result
// LANES bytes are substituted per BUSY cycle, groups in ascending order.
module inv_sub_byte
  import aes_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned LANES      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inv_valid_in,
  output logic                  inv_ready_out,
  input  logic [DATA_WIDTH-1:0] inv_data_in,
  output logic [DATA_WIDTH-1:0] inv_data_out,
  output logic                  inv_valid_out,
  input  logic                  inv_ready_in
);

  localparam int unsigned NUM_GROUPS = AES_NUM_BYTES / LANES;
  localparam int unsigned CNT_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int unsigned GROUP_BITS = LANES * AES_BYTE_BITS;
  localparam logic [CNT_W-1:0] LAST_GROUP = CNT_W'(NUM_GROUPS - 1);

  inv_state_e state, state_nxt;

  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] state_reg;
  logic [GROUP_BITS-1:0] grp_in;
  logic [GROUP_BITS-1:0] grp_out;

  // Counter-indexed group select feeding the S-box lanes
  always_comb grp_in = state_reg[cnt*GROUP_BITS +: GROUP_BITS];

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    inv_sbox u_sbox (
      .in_byte  (grp_in[l*AES_BYTE_BITS +: AES_BYTE_BITS]),
      .out_byte (grp_out[l*AES_BYTE_BITS +: AES_BYTE_BITS])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inv_valid_in) state_nxt = BUSY;
      BUSY:    if (cnt == LAST_GROUP) state_nxt = HOLD;
      HOLD:    if (inv_ready_in) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      state_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inv_valid_in) begin
            state_reg <= inv_data_in;
            cnt       <= '0;
          end
        end
        BUSY: begin
          state_reg[cnt*GROUP_BITS +: GROUP_BITS] <= grp_out;
          if (cnt != LAST_GROUP) cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    inv_ready_out = 1'b0;
    inv_valid_out = 1'b0;
    inv_data_out  = '0;
    case (state)
      IDLE: inv_ready_out = 1'b1;
      HOLD: begin
        inv_valid_out = 1'b1;
        inv_data_out  = state_reg;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_inv_sub_byte.sv
// Directed bench for inv_sub_byte (LANES = 4, 1, 16) and inv_sbox.
module tb_inv_sub_byte;

  logic clk;
  logic rst;

  logic         vin  [3];
  logic         rin  [3];
  logic [127:0] din  [3];
  logic         rdy  [3];
  logic         vout [3];
  logic [127:0] dout [3];

  logic [7:0] sb_in;
  logic [7:0] sb_out;

  int unsigned ng [3] = '{4, 16, 1};

  int checks;
  int errors;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  inv_sub_byte #(.DATA_WIDTH(128), .LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .inv_valid_in(vin[0]), .inv_ready_out(rdy[0]),
    .inv_data_in(din[0]), .inv_data_out(dout[0]), .inv_valid_out(vout[0]),
    .inv_ready_in(rin[0])
  );

  inv_sub_byte #(.DATA_WIDTH(128), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .inv_valid_in(vin[1]), .inv_ready_out(rdy[1]),
    .inv_data_in(din[1]), .inv_data_out(dout[1]), .inv_valid_out(vout[1]),
    .inv_ready_in(rin[1])
  );

  inv_sub_byte #(.DATA_WIDTH(128), .LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .inv_valid_in(vin[2]), .inv_ready_out(rdy[2]),
    .inv_data_in(din[2]), .inv_data_out(dout[2]), .inv_valid_out(vout[2]),
    .inv_ready_in(rin[2])
  );

  inv_sbox u_sb (
    .in_byte  (sb_in),
    .out_byte (sb_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Horner-form GF multiply, independent of the RTL helper
  function automatic logic [7:0] tmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      r = {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
      if (b[i]) r = r ^ a;
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = fwd_tab[s[8*k +: 8]];
    return r;
  endfunction

  task automatic run_block(input int i, input logic [127:0] d, input logic [127:0] exp,
                           input string tag);
    int lat;
    @(negedge clk);
    vin[i] = 1'b1;
    din[i] = d;
    lat = 0;
    while (rdy[i] !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_ready_idle"}, 128'(rdy[i]), 128'(1));
    @(negedge clk);
    vin[i] = 1'b0;
    din[i] = '0;
    chk({tag, "_ready_busy"}, 128'(rdy[i]), 128'(0));
    lat = 0;
    while (vout[i] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(ng[i]));
    chk({tag, "_data"}, dout[i], exp);
    chk({tag, "_ready_hold"}, 128'(rdy[i]), 128'(0));
    rin[i] = 1'b1;
    @(negedge clk);
    rin[i] = 1'b0;
    chk({tag, "_valid_drop"}, 128'(vout[i]), 128'(0));
    chk({tag, "_data_zero"}, dout[i], 128'(0));
    chk({tag, "_ready_back"}, 128'(rdy[i]), 128'(1));
  endtask

  localparam logic [127:0] FIPS_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
  localparam logic [127:0] FIPS_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

  initial begin
    logic [127:0] r;
    logic [7:0]   inv;
    int           lat;

    checks = 0;
    errors = 0;
    rst    = 1'b0;
    sb_in  = 8'h00;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0;
      rin[i] = 1'b0;
      din[i] = '0;
    end

    // Reference forward S-box: brute-force inverse then forward affine
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (a != 0 && tmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      fwd_tab[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) inv_tab[fwd_tab[a]] = 8'(a);

    // Reset state, during and after reset
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready", 128'(rdy[i]), 128'(1));
      chk("rst_valid", 128'(vout[i]), 128'(0));
      chk("rst_data", dout[i], 128'(0));
    end
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 128'(rdy[0]), 128'(1));

    // All 0x63 bytes -> all zero
    run_block(0, {16{8'h63}}, 128'(0), "all63_l4");

    // FIPS-197 C.1 round 1 on each lane count
    run_block(0, FIPS_IN, FIPS_OUT, "fips_l4");
    run_block(1, FIPS_IN, FIPS_OUT, "fips_l1");
    run_block(2, FIPS_IN, FIPS_OUT, "fips_l16");

    // Spot bytes
    run_block(0, 128'h00ED7C63, {{12{8'h52}}, 32'h52530100}, "spot_l4");

    // Exhaustive inv_sbox sweep
    for (int x = 0; x < 256; x++) begin
      sb_in = 8'(x);
      #1;
      chk("sbox_sweep", 128'(sb_out), 128'(inv_tab[x]));
    end

    // Backpressure: result held, new input ignored while in HOLD
    @(negedge clk);
    vin[0] = 1'b1;
    din[0] = FIPS_IN;
    @(negedge clk);
    vin[0] = 1'b0;
    lat = 0;
    while (vout[0] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 128'(lat), 128'(4));
    vin[0] = 1'b1;
    din[0] = {16{8'h63}};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_hold_data", dout[0], FIPS_OUT);
      chk("bp_hold_valid", 128'(vout[0]), 128'(1));
      chk("bp_hold_ready", 128'(rdy[0]), 128'(0));
    end
    rin[0] = 1'b1;
    @(negedge clk);
    rin[0] = 1'b0;
    chk("bp_release_valid", 128'(vout[0]), 128'(0));
    chk("bp_release_ready", 128'(rdy[0]), 128'(1));
    chk("bp_release_data", dout[0], 128'(0));
    @(negedge clk);
    vin[0] = 1'b0;
    din[0] = '0;
    chk("bp_next_accept", 128'(rdy[0]), 128'(0));
    lat = 0;
    while (vout[0] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_next_latency", 128'(lat), 128'(4));
    chk("bp_next_data", dout[0], 128'(0));
    rin[0] = 1'b1;
    @(negedge clk);
    rin[0] = 1'b0;

    // Reset mid-BUSY after two groups
    @(negedge clk);
    vin[0] = 1'b1;
    din[0] = {16{8'h00}};
    @(negedge clk);
    vin[0] = 1'b0;
    din[0] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 128'(rdy[0]), 128'(1));
    chk("midrst_valid", 128'(vout[0]), 128'(0));
    chk("midrst_data", dout[0], 128'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_output", 128'(vout[0]), 128'(0));
    end
    run_block(0, FIPS_IN, FIPS_OUT, "post_midrst");

    // Round trip against the reference SubBytes
    for (int n = 0; n < 1000; n++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      run_block(0, sub_bytes(r), r, "roundtrip");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
